mem_responder: RTL and testbench

Responder end of the CPU data-memory request interface: accepts one load/store request at a time from the MEM stage via a valid/ready handshake, models fixed read/write wait-states, and returns a one-cycle response with read data or an error flag.
It owns the backing word array and supersedes the zero-wait main memory.
It also drives a stall indication so the pipeline freezes while an access is outstanding.

---
 rtl/mem_pkg.sv | 32 +++
 rtl/sp_ram.sv | 34 +++
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the data-memory responder.
//   - default address/data widths
//   - latency counter width and type
//   - responder FSM state encoding
//   - helpers for latency selection and parameter legality
package mem_pkg;

  localparam int ADDR_W_DEF = 32'd22;
  localparam int DATA_W_DEF = 32'd32;

  // Latencies are limited to 1..15, so 4 bits cover the wait counter.
  localparam int CNT_W = 32'd4;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_ZERO = 4'd0;
  localparam cnt_t CNT_ONE  = 4'd1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  // Latency that applies to a request of the given direction.
  function automatic cnt_t lat_sel(input logic we, input cnt_t rd_lat, input cnt_t wr_lat);
    return we ? wr_lat : rd_lat;
  endfunction

  // True when a latency parameter fits the counter and is non-zero.
  function automatic logic lat_ok(input int lat);
    return (lat >= 32'sd1) && (lat <= 32'sd15);
  endfunction

endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port synchronous word array, no reset.
//   clk    : clock
//   we     : write enable, writes wdata to addr on the rising edge
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read of addr (value before any same-edge write)
module sp_ram #(
  parameter int DEPTH_LOG2 = 12,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int DEPTH = 32'd1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // Array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port; the caller only looks at it after a load commit.
  always_ff @(posedge clk) begin
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: responder end of the CPU data-memory request interface.
// Accepts one load/store at a time over valid/ready, waits a fixed number of
// cycles per direction, commits the access and returns a one-cycle response.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   req_valid  : request present
//   req_ready  : responder can accept this cycle
//   req_we     : 1 = store, 0 = load
//   req_addr   : word address
//   req_wdata  : store data
//   resp_valid : single-cycle response strobe
//   resp_data  : load data (0 for stores and errors)
//   resp_err   : address out of range
//   stall      : pipeline freeze request
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              stall
);

  generate
    if (!lat_ok(RD_LAT) || !lat_ok(WR_LAT) || (DEPTH_LOG2 > ADDR_W)) begin : g_param_guard
      $fatal(1, "mem_responder: RD_LAT/WR_LAT must be 1..15 and DEPTH_LOG2 <= ADDR_W");
    end
  endgenerate

  localparam cnt_t RD_LAT_C = cnt_t'(RD_LAT);
  localparam cnt_t WR_LAT_C = cnt_t'(WR_LAT);

  state_t            state_r, state_nxt;
  cnt_t              cnt_r, cnt_nxt;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              resp_valid_r;
  logic              resp_err_r;
  logic              resp_load_r;

  logic              accept_s;
  cnt_t              lat_s;
  logic              commit_s;
  logic              c_we_s;
  logic [ADDR_W-1:0] c_addr_s;
  logic [DATA_W-1:0] c_wdata_s;
  logic              in_range_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign req_ready = (state_r != ST_WAIT);
  assign accept_s  = req_valid & req_ready;
  assign stall     = req_valid & ~req_ready;
  assign lat_s     = lat_sel(req_we, RD_LAT_C, WR_LAT_C);

  // Next state, wait counter and the access to commit this edge. With a
  // latency of 1 the commit edge is the accept edge, so the live request is
  // used directly instead of the captured copy.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    commit_s  = 1'b0;
    c_we_s    = we_r;
    c_addr_s  = addr_r;
    c_wdata_s = wdata_r;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (accept_s) begin
          c_we_s    = req_we;
          c_addr_s  = req_addr;
          c_wdata_s = req_wdata;
          if (lat_s == CNT_ONE) begin
            state_nxt = ST_RESP;
            cnt_nxt   = CNT_ZERO;
            commit_s  = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = lat_s - CNT_ONE;
          end
        end else begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ONE) begin
          state_nxt = ST_RESP;
          cnt_nxt   = CNT_ZERO;
          commit_s  = 1'b1;
        end else begin
          state_nxt = ST_WAIT;
          cnt_nxt   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // In range when every bit above the implemented index is zero.
  assign in_range_s = ((c_addr_s >> DEPTH_LOG2) == '0);

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Request capture; later input changes are ignored until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (accept_s) begin
      we_r    <= req_we;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Response flags, raised on the commit edge and held for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_load_r  <= 1'b0;
    end else begin
      resp_valid_r <= commit_s;
      resp_err_r   <= commit_s & ~in_range_s;
      resp_load_r  <= commit_s & ~c_we_s & in_range_s;
    end
  end

  sp_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (commit_s & c_we_s & in_range_s),
    .addr  (c_addr_s[DEPTH_LOG2-1:0]),
    .wdata (c_wdata_s),
    .rdata (ram_rdata_s)
  );

  // The RAM read register keeps its value, so it is masked to zero unless
  // this cycle is a good load response.
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_data  = resp_load_r ? ram_rdata_s : '0;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench for mem_responder.
// Instance a: RD_LAT=2, WR_LAT=1. Instance b: RD_LAT=2, WR_LAT=3.
// One request bus is steered to either instance by sel.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, sel;
  logic        req_valid, req_we;
  logic [21:0] req_addr;
  logic [31:0] req_wdata;

  logic        a_ready, a_valid, a_err, a_stall;
  logic [31:0] a_data;
  logic        b_ready, b_valid, b_err, b_stall;
  logic [31:0] b_data;

  logic        o_ready, o_valid, o_err, o_stall;
  logic [31:0] o_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.RD_LAT(2), .WR_LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(req_valid & ~sel), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_valid), .resp_data(a_data), .resp_err(a_err), .stall(a_stall)
  );

  mem_responder #(.RD_LAT(2), .WR_LAT(3)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid & sel), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_valid), .resp_data(b_data), .resp_err(b_err), .stall(b_stall)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_err   = sel ? b_err   : a_err;
  assign o_stall = sel ? b_stall : a_stall;
  assign o_data  = sel ? b_data  : a_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request, hold it until the response appears (bounded), then
  // confirm the strobe lasts a single cycle.
  task automatic do_req(input logic we, input logic [21:0] addr, input logic [31:0] wdata,
                        output logic [31:0] data, output logic err, output int lat,
                        output logic stall_ok);
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    data = 32'h0; err = 1'b0; stall_ok = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!o_valid && lat < 20) begin
      if (o_stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    if (o_valid) begin
      data = o_data;
      err  = o_err;
    end else begin
      data = 32'h0;
      err  = 1'b0;
    end
    @(posedge clk); #1;
    check_eq("one_shot", 64'(o_valid), 64'd0);
  endtask

  logic [31:0] d;
  logic        e, s;
  int          lat;
  int          idx, nresp, nbad_valid;
  logic        acc;
  int          rcyc [0:3];
  logic [31:0] rdat [0:3];

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 22'h0; req_wdata = 32'h0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1; rst_a = 1'b0; rst_b = 1'b0;
    #2;
    check_eq("rst_ready", 64'(o_ready), 64'd1);
    check_eq("rst_valid", 64'(o_valid), 64'd0);
    check_eq("rst_data",  64'(o_data),  64'd0);
    check_eq("rst_err",   64'(o_err),   64'd0);
    req_valid = 1'b1; #1;
    check_eq("rst_stall", 64'(o_stall), 64'd0);
    req_valid = 1'b0;
    #18; rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;

    // Idle: nothing happens without requests.
    for (int i = 0; i < 20; i++) begin
      check_eq("idle", 64'({o_ready, o_stall, o_valid}), 64'b100);
      @(posedge clk); #1;
    end

    // Store then load.
    do_req(1'b1, 22'h010, 32'hDEADBEEF, d, e, lat, s);
    check_eq("st_lat", 64'(lat), 64'd1);
    check_eq("st_err", 64'(e), 64'd0);
    check_eq("st_data", 64'(d), 64'd0);
    do_req(1'b0, 22'h010, 32'h0, d, e, lat, s);
    check_eq("ld_lat", 64'(lat), 64'd2);
    check_eq("ld_data", 64'(d), 64'hDEADBEEF);
    check_eq("ld_err", 64'(e), 64'd0);
    check_eq("ld_stall", 64'(s), 64'd1);

    // Back-to-back loads with req_valid held.
    do_req(1'b1, 22'h001, 32'h11, d, e, lat, s);
    do_req(1'b1, 22'h002, 32'h22, d, e, lat, s);
    do_req(1'b1, 22'h003, 32'h33, d, e, lat, s);
    idx = 0; nresp = 0;
    req_we = 1'b0; req_addr = 22'h001; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      acc = req_valid & o_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) req_addr = 22'(idx + 1);
        else req_valid = 1'b0;
      end
      if (o_valid) begin
        if (nresp < 4) begin
          rcyc[nresp] = c;
          rdat[nresp] = o_data;
        end
        nresp++;
      end
    end
    req_valid = 1'b0;
    check_eq("b2b_count", 64'(nresp), 64'd3);
    if (nresp >= 3) begin
      check_eq("b2b_d0", 64'(rdat[0]), 64'h11);
      check_eq("b2b_d1", 64'(rdat[1]), 64'h22);
      check_eq("b2b_d2", 64'(rdat[2]), 64'h33);
      check_eq("b2b_gap1", 64'(rcyc[1] - rcyc[0]), 64'd2);
      check_eq("b2b_gap2", 64'(rcyc[2] - rcyc[1]), 64'd2);
    end

    // Out of range store must not alias onto word 0.
    do_req(1'b1, 22'h000, 32'h5A5A0000, d, e, lat, s);
    do_req(1'b1, 22'h001000, 32'h12345678, d, e, lat, s);
    check_eq("oob_st_err", 64'(e), 64'd1);
    check_eq("oob_st_data", 64'(d), 64'd0);
    do_req(1'b0, 22'h000, 32'h0, d, e, lat, s);
    check_eq("oob_alias", 64'(d), 64'h5A5A0000);
    check_eq("oob_alias_err", 64'(e), 64'd0);
    do_req(1'b0, 22'h3FF000, 32'h0, d, e, lat, s);
    check_eq("oob_ld_err", 64'(e), 64'd1);
    check_eq("oob_ld_data", 64'(d), 64'd0);

    // Same-address ordering: load presented in the store's response cycle.
    do_req(1'b1, 22'h030, 32'h0, d, e, lat, s);
    req_we = 1'b1; req_addr = 22'h030; req_wdata = 32'hA5A5A5A5; req_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("ord_st_valid", 64'(o_valid), 64'd1);
    req_we = 1'b0;
    check_eq("ord_ld_ready", 64'(o_ready), 64'd1);
    @(posedge clk); #1;
    check_eq("ord_wait", 64'({o_ready, o_valid}), 64'b00);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("ord_ld_valid", 64'(o_valid), 64'd1);
    check_eq("ord_ld_data", 64'(o_data), 64'hA5A5A5A5);
    @(posedge clk); #1;

    // Reset mid-operation on the WR_LAT=3 instance.
    sel = 1'b1;
    do_req(1'b1, 22'h020, 32'h11112222, d, e, lat, s);
    check_eq("b_st_lat", 64'(lat), 64'd3);
    req_we = 1'b1; req_addr = 22'h020; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq("b_accepted", 64'(o_ready), 64'd0);
    @(posedge clk); #1;
    rst_b = 1'b0; req_valid = 1'b1; #1;
    check_eq("mid_rst_ready", 64'(o_ready), 64'd1);
    check_eq("mid_rst_valid", 64'(o_valid), 64'd0);
    check_eq("mid_rst_data",  64'(o_data),  64'd0);
    check_eq("mid_rst_err",   64'(o_err),   64'd0);
    check_eq("mid_rst_stall", 64'(o_stall), 64'd0);
    req_valid = 1'b0;
    #3; rst_b = 1'b1;
    nbad_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (o_valid) nbad_valid++;
    end
    check_eq("mid_rst_no_resp", 64'(nbad_valid), 64'd0);
    do_req(1'b0, 22'h020, 32'h0, d, e, lat, s);
    check_eq("mid_rst_old", 64'(d), 64'h11112222);
    check_eq("mid_rst_ld_lat", 64'(lat), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
